// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants and the fetch-stage state encoding.
// Imported by fetch_stage, its IF/ID register and the IMEM interface.
package fetch_stage_pkg;

   localparam int          CPU_XLEN      = 32;
   localparam logic [31:0] CPU_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DROP  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus, one request outstanding.
// Ports: req/addr (master->slave), ready/valid/rdata (slave->master).
interface fetch_stage_if
   import fetch_stage_pkg::*;
#(
   parameter int XLEN = CPU_XLEN
);

   logic            req;
   logic [XLEN-1:0] addr;
   logic            ready;
   logic            valid;
   logic [31:0]     rdata;

   modport master (
      output req,
      output addr,
      input  ready,
      input  valid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output ready,
      output valid,
      output rdata
   );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: stall holds, squash clears, load captures.
// Ports: clk_i, rst_i, stall, squash, load, load_pc/instr -> pc/instr/valid.
module fetch_stage_ifid_reg
   import fetch_stage_pkg::*;
#(
   parameter int          XLEN      = CPU_XLEN,
   parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall,
   input  logic            squash,
   input  logic            load,
   input  logic [XLEN-1:0] load_pc,
   input  logic [31:0]     load_instr,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     instr,
   output logic            valid
);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pc    <= '0;
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (!stall) begin
         if (squash) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
         end else if (load) begin
            pc    <= load_pc;
            instr <= load_instr;
            valid <= 1'b1;
         end else begin
            // bubble keeps the last pc for debug visibility
            instr <= NOP_INSTR;
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding IMEM fetch FSM, IF/ID reg.
// Ports: clk_i, rst_i, hazard controls, redirect, imem bus, PC/IF-ID outs.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int              XLEN      = CPU_XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(CPU_RESET_PC),
   parameter logic [31:0]     NOP_INSTR = CPU_NOP_INSTR
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            PCWrite_i,
   input  logic            Stall_i,
   input  logic            Flush_i,
   input  logic [XLEN-1:0] BranchTarget_i,
   fetch_stage_if.master   imem,
   output logic [XLEN-1:0] PC_o,
   output logic [XLEN-1:0] IFIDPC_o,
   output logic [31:0]     IFIDInstr_o,
   output logic            IFIDValid_o
);

   fetch_state_e    state_q;
   fetch_state_e    state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] req_pc_q;
   logic [XLEN-1:0] req_pc_d;
   logic [31:0]     buf_q;
   logic [31:0]     buf_d;
   logic            advance;
   logic            redirect;
   logic            deliver;
   logic [31:0]     dlv_instr;

   assign advance  = PCWrite_i & ~Stall_i;
   assign redirect = Flush_i & ~Stall_i;

   assign imem.req  = rst_i & (state_q == FETCH);
   assign imem.addr = pc_q;
   assign PC_o      = pc_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
         buf_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         buf_q    <= buf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_pc_d  = req_pc_q;
      buf_d     = buf_q;
      deliver   = 1'b0;
      dlv_instr = buf_q;
      unique case (state_q)
         FETCH: begin
            if (imem.ready) begin
               req_pc_d = pc_q;
               // accepted together with a redirect: response is stale
               state_d  = redirect ? DROP : WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               state_d = imem.valid ? FETCH : DROP;
            end else if (imem.valid) begin
               if (advance) begin
                  deliver   = 1'b1;
                  dlv_instr = imem.rdata;
                  state_d   = FETCH;
               end else begin
                  buf_d   = imem.rdata;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               state_d = FETCH;
            end else if (advance) begin
               deliver = 1'b1;
               state_d = FETCH;
            end
         end
         DROP: begin
            // a redirect here only moves the PC; the stale
            // response still has to be swallowed
            if (imem.valid) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      if (redirect) begin
         pc_d = BranchTarget_i;
      end else if (deliver) begin
         pc_d = req_pc_q + XLEN'(4);
      end
   end

   fetch_stage_ifid_reg #(
      .XLEN      (XLEN),
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .stall      (Stall_i),
      .squash     (redirect),
      .load       (deliver),
      .load_pc    (req_pc_q),
      .load_instr (dlv_instr),
      .pc         (IFIDPC_o),
      .instr      (IFIDInstr_o),
      .valid      (IFIDValid_o)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle vector table,
// reset corner sequence and a random-stall scoreboard stream.
module tb_fetch_stage;

   localparam logic [31:0] NOPW = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        pcw;
   logic        stall;
   logic        flush;
   logic [31:0] target;
   logic [31:0] pc;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;

   fetch_stage_if #(.XLEN(32)) bus ();

   fetch_stage dut (
      .clk_i          (clk),
      .rst_i          (rst_n),
      .PCWrite_i      (pcw),
      .Stall_i        (stall),
      .Flush_i        (flush),
      .BranchTarget_i (target),
      .imem           (bus),
      .PC_o           (pc),
      .IFIDPC_o       (ifid_pc),
      .IFIDInstr_o    (ifid_instr),
      .IFIDValid_o    (ifid_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_fail;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        pw;
      logic        st;
      logic        fl;
      logic [31:0] tgt;
      logic        rdy;
      logic        vld;
      logic [31:0] dat;
      logic        e_req;
      logic [31:0] e_pc;
      logic        e_iv;
      logic [31:0] e_ipc;
      logic [31:0] e_ins;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic pw, input logic st, input logic fl,
      input logic [31:0] tgt,
      input logic rdy, input logic vld,
      input logic [31:0] dat,
      input logic e_req, input logic [31:0] e_pc,
      input logic e_iv, input logic [31:0] e_ipc,
      input logic [31:0] e_ins);
      vec_t v;
      v.pw = pw; v.st = st; v.fl = fl; v.tgt = tgt;
      v.rdy = rdy; v.vld = vld; v.dat = dat;
      v.e_req = e_req; v.e_pc = e_pc; v.e_iv = e_iv;
      v.e_ipc = e_ipc; v.e_ins = e_ins;
      return v;
   endfunction

   logic [31:0] exp_q[$];

   initial begin
      int          pend;
      int          cnt;
      int          delivered;
      logic [31:0] paddr;
      logic [31:0] nxt;
      logic [31:0] e;
      logic        acc;
      logic        drain;

      n_chk  = 0;
      n_fail = 0;

      // pw st fl tgt | rdy vld dat | req pc iv ipc ins
      tbl.push_back(mk(1,0,0,0, 1,0,0, 1,0,0,0,NOPW));
      tbl.push_back(mk(1,0,0,0, 0,1,32'hA0, 0,0,0,0,NOPW));
      tbl.push_back(mk(1,0,0,0, 1,0,0, 1,4,1,0,32'hA0));
      tbl.push_back(mk(1,0,0,0, 0,1,32'hA4, 0,4,0,0,NOPW));
      tbl.push_back(mk(0,1,0,0, 1,0,0, 1,8,1,4,32'hA4));
      tbl.push_back(mk(0,1,0,0, 0,1,32'hA8, 0,8,1,4,32'hA4));
      tbl.push_back(mk(0,1,0,0, 0,0,0, 0,8,1,4,32'hA4));
      tbl.push_back(mk(0,1,1,32'h200, 0,0,0, 0,8,1,4,32'hA4));
      tbl.push_back(mk(1,0,0,0, 0,0,0, 0,8,1,4,32'hA4));
      tbl.push_back(mk(1,0,0,0, 1,0,0, 1,32'hC,1,8,32'hA8));
      tbl.push_back(mk(1,0,1,32'h100, 0,0,0, 0,32'hC,0,8,NOPW));
      tbl.push_back(mk(1,0,0,0, 0,1,32'hAC, 0,32'h100,0,0,NOPW));
      tbl.push_back(mk(1,0,0,0, 1,0,0, 1,32'h100,0,0,NOPW));
      tbl.push_back(mk(1,0,1,32'h300, 0,1,32'h1A0,
                       0,32'h100,0,0,NOPW));
      tbl.push_back(mk(1,0,0,0, 0,0,0, 1,32'h300,0,0,NOPW));
      tbl.push_back(mk(1,0,0,0, 1,1,32'hDEAD, 1,32'h300,0,0,NOPW));
      tbl.push_back(mk(0,0,0,0, 0,1,32'h3A0, 0,32'h300,0,0,NOPW));
      tbl.push_back(mk(0,0,0,0, 0,0,0, 0,32'h300,0,0,NOPW));
      tbl.push_back(mk(0,0,1,32'h400, 0,0,0, 0,32'h300,0,0,NOPW));
      tbl.push_back(mk(1,0,1,32'h500, 1,0,0, 1,32'h400,0,0,NOPW));
      tbl.push_back(mk(1,0,1,32'h600, 0,0,0, 0,32'h500,0,0,NOPW));
      tbl.push_back(mk(1,0,0,0, 0,1,32'h4A0, 0,32'h600,0,0,NOPW));
      tbl.push_back(mk(1,0,0,0, 1,0,0, 1,32'h600,0,0,NOPW));
      tbl.push_back(mk(1,0,1,32'hFFFF_FFFC, 0,0,0,
                       0,32'h600,0,0,NOPW));
      tbl.push_back(mk(1,0,0,0, 0,1,32'h6A0,
                       0,32'hFFFF_FFFC,0,0,NOPW));
      tbl.push_back(mk(1,0,0,0, 1,0,0, 1,32'hFFFF_FFFC,0,0,NOPW));
      tbl.push_back(mk(1,0,0,0, 0,0,0, 0,32'hFFFF_FFFC,0,0,NOPW));
      tbl.push_back(mk(1,0,0,0, 0,1,32'h1234_5678,
                       0,32'hFFFF_FFFC,0,0,NOPW));
      tbl.push_back(mk(1,0,0,0, 1,0,0,
                       1,0,1,32'hFFFF_FFFC,32'h1234_5678));
      tbl.push_back(mk(1,0,0,0, 0,1,32'hA0,
                       0,0,0,32'hFFFF_FFFC,NOPW));
      tbl.push_back(mk(1,0,0,0, 0,0,0, 1,4,1,0,32'hA0));
      tbl.push_back(mk(1,0,1,32'h800, 0,0,0, 1,4,0,0,NOPW));
      tbl.push_back(mk(1,0,0,0, 1,0,0, 1,32'h800,0,0,NOPW));

      rst_n     = 1'b0;
      pcw       = 1'b1;
      stall     = 1'b0;
      flush     = 1'b0;
      target    = '0;
      bus.ready = 1'b1;
      bus.valid = 1'b0;
      bus.rdata = '0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst req", 32'(bus.req), 0);
      chk("rst pc", pc, 0);
      chk("rst ifid valid", 32'(ifid_valid), 0);
      chk("rst ifid instr", ifid_instr, NOPW);
      chk("rst ifid pc", ifid_pc, 0);

      @(negedge clk);
      rst_n = 1'b1;
      foreach (tbl[i]) begin
         pcw       = tbl[i].pw;
         stall     = tbl[i].st;
         flush     = tbl[i].fl;
         target    = tbl[i].tgt;
         bus.ready = tbl[i].rdy;
         bus.valid = tbl[i].vld;
         bus.rdata = tbl[i].dat;
         #1;
         chk($sformatf("v%0d req", i), 32'(bus.req),
             32'(tbl[i].e_req));
         chk($sformatf("v%0d pc", i), pc, tbl[i].e_pc);
         if (tbl[i].e_req)
            chk($sformatf("v%0d addr", i), bus.addr, tbl[i].e_pc);
         chk($sformatf("v%0d ifid valid", i), 32'(ifid_valid),
             32'(tbl[i].e_iv));
         chk($sformatf("v%0d ifid pc", i), ifid_pc, tbl[i].e_ipc);
         chk($sformatf("v%0d ifid instr", i), ifid_instr,
             tbl[i].e_ins);
         @(negedge clk);
      end

      // reset while WAIT is pending on the request to 0x800
      pcw = 1'b1; stall = 1'b0; flush = 1'b0;
      bus.ready = 1'b0; bus.valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid rst pc", pc, 0);
      chk("mid rst req", 32'(bus.req), 0);
      chk("mid rst ifid valid", 32'(ifid_valid), 0);
      chk("mid rst ifid instr", ifid_instr, NOPW);
      @(negedge clk);
      rst_n = 1'b1;
      bus.valid = 1'b1; bus.rdata = 32'hDEAD;
      #1;
      chk("post rst req", 32'(bus.req), 1);
      @(negedge clk);
      bus.valid = 1'b0; bus.ready = 1'b1;
      #1;
      chk("stray req", 32'(bus.req), 1);
      chk("stray pc", pc, 0);
      chk("stray ifid valid", 32'(ifid_valid), 0);
      @(negedge clk);
      bus.ready = 1'b0; bus.valid = 1'b1; bus.rdata = 32'hA0;
      #1;
      chk("post rst wait req", 32'(bus.req), 0);
      @(negedge clk);
      bus.valid = 1'b0;
      #1;
      chk("post rst ifid valid", 32'(ifid_valid), 1);
      chk("post rst ifid instr", ifid_instr, 32'hA0);
      chk("post rst pc", pc, 4);

      // random stalls, pc holds and latency; no redirects
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      pend = 0; cnt = 0; paddr = '0; nxt = '0; delivered = 0;
      for (int c = 0; c < 600; c++) begin
         drain = (c >= 560);
         if (c > 0) @(negedge clk);
         pcw   = drain ? 1'b1 : ($urandom_range(0, 4) != 0);
         stall = drain ? 1'b0 : ($urandom_range(0, 3) == 0);
         flush = 1'b0;
         bus.ready = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
         if (pend != 0 && cnt == 0) begin
            bus.valid = 1'b1;
            bus.rdata = 32'hA0 + paddr;
         end else begin
            bus.valid = 1'b0;
            bus.rdata = '0;
         end
         #1;
         acc = bus.req & bus.ready;
         if (acc) begin
            chk("rnd addr", bus.addr, nxt);
            exp_q.push_back(nxt);
            nxt = nxt + 32'd4;
         end
         @(posedge clk);
         #1;
         if (bus.valid) pend = 0;
         else if (pend != 0 && cnt > 0) cnt--;
         if (acc) begin
            pend  = 1;
            cnt   = $urandom_range(0, 2);
            paddr = bus.addr;
         end
         if (!stall && ifid_valid) begin
            if (exp_q.size() == 0) begin
               chk("rnd unexpected delivery", ifid_pc, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               delivered++;
               chk("rnd ifid pc", ifid_pc, e);
               chk("rnd ifid instr", ifid_instr, 32'hA0 + e);
               chk("rnd pc", pc, e + 32'd4);
            end
         end
      end
      chk("rnd drained", 32'(exp_q.size()), 0);
      chk("rnd progress", 32'(delivered > 20), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage: owns the PC register, a single-outstanding-request handshake to instruction memory, and the IF/ID pipeline register. It is the consumer of the load-use hazard controls (PCWrite_i, Stall_i) and of the ID-stage branch redirect (Flush_i). It absorbs variable instruction-memory latency and delivers bubbles to ID while a fetch is pending.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, instruction word driven on IF/ID when invalid (addi x0,x0,0)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
PCWrite_i  input  1  1 = PC may advance (from hazard detection)
Stall_i  input  1  1 = hold IF/ID register (from hazard detection)
Flush_i  input  1  taken branch/jump resolved in ID; redirect and squash IF/ID
BranchTarget_i  input  XLEN  redirect target, valid with Flush_i
IMemReq_o  output  1  fetch request valid
IMemAddr_o  output  XLEN  fetch address (equals PC_o while requesting)
IMemReady_i  input  1  memory accepts request this cycle
IMemValid_i  input  1  response valid (at earliest 1 cycle after acceptance)
IMemData_i  input  32  response instruction word
PC_o  output  XLEN  current PC register
IFIDPC_o  output  XLEN  IF/ID: PC of held instruction
IFIDInstr_o  output  32  IF/ID: instruction
IFIDValid_o  output  1  IF/ID: instruction valid (0 = bubble)

Behaviour:
- Reset (rst_i=0, async): PC_o=RESET_PC, state=FETCH, IMemReq_o=0 during reset, IFIDValid_o=0, IFIDInstr_o=NOP_INSTR, IFIDPC_o=0, buffer cleared. Reset mid-request abandons it; memory shares the reset.
- advance = PCWrite_i & ~Stall_i. redirect = Flush_i & ~Stall_i. When Stall_i=1, Flush_i is ignored.
- States: FETCH, WAIT, HOLD, DROP. IMemReq_o=1 only in FETCH (out of reset), IMemAddr_o=PC_o.
- FETCH: IMemReady_i=1 -> latch req_pc=PC_o, go WAIT. IMemValid_i is ignored in FETCH.
- WAIT, on IMemValid_i:
  - advance=1: load IF/ID {req_pc, IMemData_i, 1}, PC<=req_pc+4, go FETCH.
  - advance=0: capture the word in the 1-entry buffer, go HOLD.
- HOLD: when advance=1, load IF/ID from the buffer, PC<=req_pc+4, go FETCH.
- IF/ID update each cycle:
  - Stall_i=1: hold all three fields.
  - Else if redirect: squash to {0, NOP_INSTR, 0}.
  - Else if an instruction is delivered: load it.
  - Else: valid=0 and instr=NOP_INSTR (bubble).
- Redirect (priority over every delivery): PC<=BranchTarget_i.
  - FETCH: go FETCH, but if IMemReady_i=1 the same cycle, the accepted request is stale -> go DROP.
  - WAIT: if IMemValid_i is high the same cycle, discard and go FETCH; else go DROP.
  - HOLD: discard the buffer, go FETCH.
  - DROP: stay DROP with the new PC.
- DROP: on IMemValid_i, discard the data and go FETCH.
- PC arithmetic is modulo 2^XLEN; 0xFFFF_FFFC+4 wraps to 0.
- PCWrite_i=0 with Stall_i=0: PC holds, IF/ID takes a bubble, and a fetched word waits in HOLD.
- Latency: 1-cycle memory gives a 1-instruction-per-2-cycles baseline (request cycle + response cycle).

Decomposition:
- Shared cpu package: XLEN, NOP_INSTR, RESET_PC defaults, and the fetch state enum {FETCH, WAIT, HOLD, DROP}. The hazard and ID stages reuse the constants.
- One natural sub-module, ifid_reg: the IF/ID register with stall/squash/load priority. The PC, FSM and buffer stay in fetch_stage.

Test Plan:
- Reset, RESET_PC=0, memory ready always with 1-cycle latency returning 0xA0+addr -> IMemAddr_o sequence 0,4,8; IF/ID shows {0,0xA0,1}, then bubble, then {4,0xA4,1}.
- Response arrives with Stall_i=1, PCWrite_i=0 for 3 cycles -> state HOLD, IF/ID unchanged, no new request; when released, the buffered word loads and the next request is at addr+4.
- Flush_i with target 0x100 during WAIT, response next cycle -> response discarded, IFIDValid_o=0, next request addr 0x100.
- Flush_i and IMemValid_i in the same WAIT cycle -> data discarded, next cycle IMemReq_o=1 at target.
- Flush_i with Stall_i=1 -> flush ignored, PC and IF/ID held; Flush_i repeated with Stall_i=0 -> redirect taken.
- rst_i asserted while in WAIT -> immediately PC_o=RESET_PC, IFIDValid_o=0, IMemReq_o=0; after release, a stray IMemValid_i in FETCH is ignored.
